// File: rtl/v_hier_arb_pkg.sv
// v_hier_arb_pkg: shared state encoding and limits for the v_hier arbiter.
package v_hier_arb_pkg;

    localparam int STATE_W     = 2;
    localparam int MIN_SUB_LAT = 1;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/v_hier_rr_pick.sv
// v_hier_rr_pick: combinational round-robin picker. Searches upward from
// last+1, wrapping modulo NREQ, and returns the first set request.
module v_hier_rr_pick #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    // First requester after the pointer wins; exactly one gnt bit or none.
    always_comb begin : p_pick
        logic found;
        int   idx;
        found   = 1'b0;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last) + off) % NREQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt          = '0;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx[IDX_W-1:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/v_hier_arb.sv
// v_hier_arb: round-robin arbiter/sequencer sharing one v_hier_sub among
// NREQ requesters. Define V_HIER_ARB_PRIO_EN to give requester 0 absolute
// priority (its grants do not move the round-robin pointer).
//
// Handshake: a requester holds req_valid/req_data until it sees its
// req_ready bit; req_ready is a one-cycle combinational accept that only
// appears in IDLE. rsp_valid is a one-cycle registered pulse to the same
// requester, with rsp_data held until the next capture.
module v_hier_arb
    import v_hier_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 4,
    parameter int SUB_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [WIDTH-1:0]      sub_avec,
    input  logic [WIDTH-1:0]      sub_qvec,
    output logic                  busy,
    output logic [STATE_W-1:0]    dbg_state
);

    localparam int LAT   = (SUB_LAT < MIN_SUB_LAT) ? MIN_SUB_LAT : SUB_LAT;
    localparam int CNT_W = $clog2(LAT + 1);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  last_grant;
    logic [NREQ-1:0]   gnt_q;

    logic [NREQ-1:0]   rr_gnt;
    logic [IDX_W-1:0]  rr_idx;
    logic              any_req;

    logic              prio;
    logic [NREQ-1:0]   sel_gnt;
    logic [IDX_W-1:0]  sel_idx;

    v_hier_rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req_valid),
        .last    (last_grant),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (any_req)
    );

    // Requester 0 overrides the round-robin choice only in the priority build.
    always_comb begin
`ifdef V_HIER_ARB_PRIO_EN
        prio = req_valid[0];
`else
        prio = 1'b0;
`endif
        sel_gnt = rr_gnt;
        sel_idx = rr_idx;
        if (prio) begin
            sel_gnt    = '0;
            sel_gnt[0] = 1'b1;
            sel_idx    = '0;
        end
    end

    // Accept pulse is visible only in IDLE and is forced low while in reset.
    assign req_ready = (state == IDLE && !rst) ? sel_gnt : '0;
    assign dbg_state = state;

    // Sequencer: accept, wait out the sub latency, capture, pulse response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= IDX_W'(NREQ - 1);
            gnt_q      <= '0;
            sub_avec   <= '0;
            rsp_data   <= '0;
            rsp_valid  <= '0;
            busy       <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sub_avec <= req_data[int'(sel_idx)*WIDTH +: WIDTH];
                        if (!prio) last_grant <= sel_idx;
                        gnt_q    <= sel_gnt;
                        cnt      <= CNT_W'(LAT);
                        busy     <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        rsp_data  <= sub_qvec;
                        rsp_valid <= gnt_q;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v_hier_arb.sv
// tb_v_hier_arb: directed, table-driven bench for v_hier_arb with a
// behavioural sub model (qvec = avec ^ 4'hF after SUB_LAT cycles).
module tb_v_hier_arb;
    import v_hier_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (SUB_LAT=2) ----------------
    logic [3:0]  req_valid = '0;
    logic [15:0] req_data  = '0;
    logic [3:0]  req_ready, rsp_valid, rsp_data, sub_avec, sub_qvec;
    logic        busy;
    logic [STATE_W-1:0] dbg_state;

    v_hier_arb #(.NREQ(4), .WIDTH(4), .SUB_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sub_avec(sub_avec), .sub_qvec(sub_qvec), .busy(busy), .dbg_state(dbg_state)
    );

    logic [3:0] q_m = '0;
    always @(posedge clk) q_m <= sub_avec ^ 4'hF;
    assign sub_qvec = q_m;

    // ---------------- latency sweep DUTs (SUB_LAT=1 and 5) ----------------
    logic [3:0]  valid_s = '0;
    logic [15:0] data_s  = '0;
    logic [3:0]  ready_l1, rspv_l1, rspd_l1, avec_l1, qvec_l1;
    logic [3:0]  ready_l5, rspv_l5, rspd_l5, avec_l5, qvec_l5;
    logic        busy_l1, busy_l5;
    logic [STATE_W-1:0] st_l1, st_l5;

    v_hier_arb #(.NREQ(4), .WIDTH(4), .SUB_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(valid_s), .req_data(data_s),
        .req_ready(ready_l1), .rsp_valid(rspv_l1), .rsp_data(rspd_l1),
        .sub_avec(avec_l1), .sub_qvec(qvec_l1), .busy(busy_l1), .dbg_state(st_l1)
    );
    assign qvec_l1 = avec_l1 ^ 4'hF;

    v_hier_arb #(.NREQ(4), .WIDTH(4), .SUB_LAT(5)) u_l5 (
        .clk(clk), .rst(rst), .req_valid(valid_s), .req_data(data_s),
        .req_ready(ready_l5), .rsp_valid(rspv_l5), .rsp_data(rspd_l5),
        .sub_avec(avec_l5), .sub_qvec(qvec_l5), .busy(busy_l5), .dbg_state(st_l5)
    );
    logic [3:0] p5 [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    always @(posedge clk) begin
        p5[0] <= avec_l5 ^ 4'hF;
        for (int i = 1; i < 4; i++) p5[i] <= p5[i-1];
    end
    assign qvec_l5 = p5[3];

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  valid;
        logic [15:0] data;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_avec;
        logic [3:0]  exp_rsp;
    } vec_t;

    vec_t tbl [6];
    logic [3:0] pexp [3];
    int first_l1, first_l5;
    logic [3:0] d_l1, d_l5, v_l1, v_l5;

    initial begin
        // Sequence starts from reset (pointer at 3); each row depends on the previous grant.
        tbl[0] = '{4'b0100, 16'h0A00, 4'b0100, 4'hA, 4'h5};  // single request
        tbl[1] = '{4'b1111, 16'h4321, 4'b1000, 4'h4, 4'hB};  // pointer 2 -> 3
        tbl[2] = '{4'b1010, 16'h7654, 4'b0010, 4'h5, 4'hA};  // wrap: 3 -> 1 over 3
        tbl[3] = '{4'b0001, 16'h000C, 4'b0001, 4'hC, 4'h3};
        tbl[4] = '{4'b1001, 16'h900E, 4'b1000, 4'h9, 4'h6};  // pointer 0 -> 3
        tbl[5] = '{4'b0011, 16'h0027, 4'b0001, 4'h7, 4'h8};  // pointer 3 wraps to 0
`ifdef V_HIER_ARB_PRIO_EN
        pexp[0] = 4'b0001; pexp[1] = 4'b0001; pexp[2] = 4'b0001;
`else
        pexp[0] = 4'b0100; pexp[1] = 4'b0001; pexp[2] = 4'b0100;
`endif

        do_reset();
        mid();
        check("reset_ready", req_ready, 4'b0000);
        check("reset_rsp_valid", rsp_valid, 4'b0000);
        check("reset_busy", busy, 1'b0);
        check("reset_avec", sub_avec, 4'h0);
        check("reset_rsp_data", rsp_data, 4'h0);
        check("reset_state", dbg_state, IDLE);

        // ---- table-driven single transactions ----
        for (int i = 0; i < 6; i++) begin
            next_cyc();                          // cycle T
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            mid();
            check($sformatf("v%0d_ready_T", i), req_ready, tbl[i].exp_gnt);
            check($sformatf("v%0d_busy_T", i), busy, 1'b0);
            next_cyc();                          // T+1
            req_valid = '0;
            mid();
            check($sformatf("v%0d_avec", i), sub_avec, tbl[i].exp_avec);
            check($sformatf("v%0d_busy_T1", i), busy, 1'b1);
            check($sformatf("v%0d_state_T1", i), dbg_state, WAIT);
            check($sformatf("v%0d_ready_T1", i), req_ready, 4'b0000);
            next_cyc();                          // T+2
            mid();
            check($sformatf("v%0d_rspv_T2", i), rsp_valid, 4'b0000);
            check($sformatf("v%0d_busy_T2", i), busy, 1'b1);
            next_cyc();                          // T+3
            mid();
            check($sformatf("v%0d_rspv_T3", i), rsp_valid, tbl[i].exp_gnt);
            check($sformatf("v%0d_rspd_T3", i), rsp_data, tbl[i].exp_rsp);
            check($sformatf("v%0d_busy_T3", i), busy, 1'b1);
            check($sformatf("v%0d_state_T3", i), dbg_state, RESP);
            next_cyc();                          // T+4
            mid();
            check($sformatf("v%0d_rspv_T4", i), rsp_valid, 4'b0000);
            check($sformatf("v%0d_busy_T4", i), busy, 1'b0);
            check($sformatf("v%0d_rspd_hold", i), rsp_data, tbl[i].exp_rsp);
        end

        // ---- fairness: all four held valid from reset ----
        do_reset();
        req_valid = 4'b1111;
        req_data  = 16'h4321;
        for (int c = 0; c <= 16; c++) begin
            mid();
            if (c % 4 == 0) check($sformatf("fair_c%0d", c), req_ready, 4'b0001 << ((c / 4) % 4));
            else            check($sformatf("fair_c%0d", c), req_ready, 4'b0000);
            next_cyc();
        end
        req_valid = '0;
        for (int c = 0; c < 4; c++) next_cyc();

        // ---- reset in the middle of a transaction ----
        req_valid = 4'b0010;
        req_data  = 16'h0030;
        mid();
        check("rst_accept", req_ready, 4'b0010);
        next_cyc();                              // T+1
        req_valid = '0;
        next_cyc();                              // T+2
        rst = 1'b1;
        #1;
        check("rst_rspv_now", rsp_valid, 4'b0000);
        check("rst_busy_now", busy, 1'b0);
        check("rst_avec_now", sub_avec, 4'h0);
        check("rst_rspd_now", rsp_data, 4'h0);
        check("rst_state_now", dbg_state, IDLE);
        next_cyc();
        next_cyc();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mid();
            check($sformatf("rst_no_rsp_c%0d", c), rsp_valid, 4'b0000);
            next_cyc();
        end
        req_valid = 4'b0011;
        req_data  = 16'h0021;
        mid();
        check("rst_first_winner", req_ready, 4'b0001);
        next_cyc();
        req_valid = '0;
        for (int c = 0; c < 4; c++) next_cyc();

        // ---- priority / alternation with requesters 0 and 2, pointer at 0 ----
        req_valid = 4'b0101;
        req_data  = 16'h0304;
        for (int k = 0; k < 3; k++) begin
            mid();
            check($sformatf("prio_g%0d", k), req_ready, pexp[k]);
            if (k < 2) for (int c = 0; c < 4; c++) next_cyc();
        end
        next_cyc();
        req_valid = 4'b0100;
        next_cyc();
        next_cyc();
        next_cyc();
        mid();
        check("prio_drop0", req_ready, 4'b0100);
        next_cyc();
        req_valid = '0;
        for (int c = 0; c < 4; c++) next_cyc();

        // ---- latency sweep: SUB_LAT=1 and 5 side by side ----
        first_l1 = -1;
        first_l5 = -1;
        d_l1 = '0; d_l5 = '0; v_l1 = '0; v_l5 = '0;
        valid_s = 4'b0100;
        data_s  = 16'h0A00;
        mid();
        check("lat1_ready", ready_l1, 4'b0100);
        check("lat5_ready", ready_l5, 4'b0100);
        for (int c = 1; c <= 9; c++) begin
            next_cyc();
            if (c == 1) valid_s = '0;
            mid();
            if (rspv_l1 != 4'b0000 && first_l1 < 0) begin first_l1 = c; d_l1 = rspd_l1; v_l1 = rspv_l1; end
            if (rspv_l5 != 4'b0000 && first_l5 < 0) begin first_l5 = c; d_l5 = rspd_l5; v_l5 = rspv_l5; end
        end
        check("lat1_rsp_cycle", first_l1, 2);
        check("lat1_rsp_vec", v_l1, 4'b0100);
        check("lat1_rsp_data", d_l1, 4'h5);
        check("lat5_rsp_cycle", first_l5, 6);
        check("lat5_rsp_vec", v_l5, 4'b0100);
        check("lat5_rsp_data", d_l5, 4'h5);

        // ---- final report ----
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/v_hier_arb.md
# v_hier_arb

Round-robin arbiter and sequencer that shares one `v_hier_sub` instance among NREQ requesters. It accepts one 4-bit operand at a time and drives it onto the sub's `avec` input. It waits a fixed pipeline latency, captures `qvec`, and returns the result to the granted requester. It sits in `v_hier_top` between the requester ports and the `sub` instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 4: operand/result width; matches sub `avec`/`qvec`.
- `SUB_LAT`, 2: cycles from `sub_avec` change to valid `sub_qvec`, ≥1.
- `clk` in 1: the single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: per-requester request.
- `req_data` in NREQ*WIDTH: operands; requester i owns bits [i*WIDTH +: WIDTH].
- `req_ready` out NREQ: one-hot accept pulse.
- `rsp_valid` out NREQ: one-hot result pulse.
- `rsp_data` out WIDTH: result, shared by all requesters.
- `sub_avec` out WIDTH: drives sub `avec`.
- `sub_qvec` in WIDTH: from sub `qvec`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE → WAIT on accept.
  - WAIT → RESP when the latency counter expires.
  - RESP → IDLE unconditionally.
- IDLE with any `req_valid`:
  - Grant g is the first set `req_valid` bit searching upward from `last_grant+1`, wrapping modulo NREQ.
  - `req_ready[g]`=1 combinationally in that cycle.
  - At the edge: `sub_avec`←`req_data[g]`, `last_grant`←g, `cnt`←SUB_LAT, go to WAIT.
- WAIT: `cnt` decrements each cycle. When `cnt`==1, `rsp_data`←`sub_qvec` at the edge and go to RESP.
- RESP: `rsp_valid[g]`=1 for exactly one cycle. `rsp_data` is stable until the next capture.
- Requesters hold `req_valid`/`req_data` until they see `req_ready`. Dropping `req_valid` before a grant is legal and simply forfeits that request.
- `req_ready` is 0 outside IDLE. A request arriving during WAIT/RESP waits.
- `sub_avec` holds its last operand between transactions.
- Reset values: `sub_avec`=0, `rsp_data`=0, `req_ready`=0, `rsp_valid`=0, `busy`=0, state=IDLE, `last_grant`=NREQ-1 (requester 0 wins first), `cnt`=0.
- Reset asserted mid-transaction: the transaction is dropped, no `rsp_valid` is produced, and all registers return to reset values immediately.

## Timing
- Accept in cycle T. `sub_avec` is valid from T+1.
- `sub_qvec` is sampled at the end of cycle T+SUB_LAT.
- `rsp_valid` is high in cycle T+SUB_LAT+1.
- The earliest next accept is T+SUB_LAT+2, so throughput is one transaction per SUB_LAT+2 cycles.
- `req_ready` is combinational from state, `req_valid` and `last_grant`. All other outputs are registered.

## Configuration
- `V_HIER_ARB_PRIO_EN` defined: requester 0 is high priority.
  - Whenever `req_valid[0]` is set in IDLE, requester 0 is granted regardless of pointer.
  - `last_grant` is not updated on such a priority grant.
  - Other requesters use round-robin as normal.
- Not defined: pure round-robin for all requesters, including 0.

## Structure
- Package `v_hier_arb_pkg`:
  - State encoding constants IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - State width constant.
  - Minimum SUB_LAT constant (1).
- Sub-module `v_hier_rr_pick`: purely combinational.
  - Inputs: request vector, last-grant index.
  - Outputs: one-hot grant vector, grant index, any-request flag.
  - Instantiated once.
- Latency counter width is $clog2(SUB_LAT+1).

## Test plan
- Single request: `req_valid`=4'b0100, `req_data[2]`=4'hA, sub model returns `avec`^4'hF after 2 cycles.
  - `req_ready`=4'b0100 at T.
  - `sub_avec`=4'hA at T+1.
  - `rsp_valid`=4'b0100 with `rsp_data`=4'h5 at T+3.
  - `busy` high T+1..T+3.
- Fairness: all four requesters held valid.
  - Grants in order 0,1,2,3,0 at cycles 0,4,8,12,16.
  - No `req_ready` in any other cycle.
- Wrap-around: after a grant to 3, requesters 1 and 3 valid → requester 1 granted next.
- Reset mid-operation: assert `rst` at T+2 of a transaction.
  - No `rsp_valid` appears.
  - Outputs read 0 in the same cycle.
  - After release, requester 0 wins first.
- Priority: with `V_HIER_ARB_PRIO_EN` defined, requesters 0 and 2 held valid and `last_grant`=0.
  - Grants go 0,0,0.
  - Drop `req_valid[0]` → requester 2 is granted next.
  - Without the macro, grants alternate 2,0,2.
- Latency sweep: repeat the single-request test with SUB_LAT=1 and 5.
  - `rsp_valid` lands at T+2 and T+6 respectively.
